// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx between NREQ byte sources.
//   clk       rising-edge clock
//   ret       async active-low reset
//   en        1 = new grants allowed (a running frame always completes)
//   req       per-requester "byte ready"
//   req_data  byte of requester i at [i*DW +: DW]
//   gnt       one-hot 1-cycle pulse: requester's byte taken
//   tx_data   byte presented to uart_tx, held until the next grant
//   tx_start  1-cycle launch pulse to uart_tx
//   tx_busy   uart_tx busy, high for the whole frame
//   owner     index of the most recently granted requester
//   active    high while a frame is launched or in flight
//   err       1-cycle pulse when uart_tx never raised tx_busy
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int TMO  = 16
) (
  input  logic                    clk,
  input  logic                    ret,
  input  logic                    en,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         gnt,
  output logic [DW-1:0]           tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    active,
  output logic                    err
);
  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TMO);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, SEND} st_t;

  st_t           st;
  logic [PW-1:0] rr_ptr;
  logic [TW-1:0] tmo_cnt;

  // Rotated request view: rot[k] is the requester k places after rr_ptr.
  logic [NREQ-1:0] rot;
  logic [PW-1:0]   sel;
  logic            hit;

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_rot
      assign rot[g] = req[(int'(rr_ptr) + g) % NREQ];
    end
  endgenerate

  // Descending scan so the lowest rotated offset (closest to rr_ptr) wins.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        hit = 1'b1;
        sel = PW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign active = (st != IDLE);

  always_ff @(posedge clk or negedge ret) begin
    if (!ret) begin
      st       <= IDLE;
      rr_ptr   <= '0;
      tmo_cnt  <= '0;
      gnt      <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      owner    <= '0;
      err      <= 1'b0;
    end else begin
      gnt      <= '0;
      tx_start <= 1'b0;
      err      <= 1'b0;
      case (st)
        IDLE: begin
          if (en && hit) begin
            gnt[sel] <= 1'b1;
            tx_start <= 1'b1;
            tx_data  <= req_data[int'(sel)*DW +: DW];
            owner    <= sel;
            rr_ptr   <= (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
            tmo_cnt  <= '0;
            st       <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            st <= SEND;
          end else if (tmo_cnt == TW'(TMO - 1)) begin
            // rr_ptr already advanced at grant; the dropped byte is not retried.
            err <= 1'b1;
            st  <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        SEND: begin
          if (!tx_busy) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TMO  = 16;

  logic             clk = 1'b0;
  logic             ret = 1'b0;
  logic             en  = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]  gnt;
  logic [DW-1:0]    tx_data;
  logic             tx_start;
  logic             tx_busy = 1'b0;
  logic [1:0]       owner;
  logic             active;
  logic             err;

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .ret(ret), .en(en), .req(req), .req_data(req_data),
    .gnt(gnt), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .owner(owner), .active(active), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: "free" means the arbiter may hand out the line; a launched
  // frame is either waiting for uart_tx to react or being sent.
  int              m_ph;      // 0 free, 1 launched, 2 sending
  int              m_ptr;     // first requester to consider next time
  int              m_wait;    // cycles spent waiting for tx_busy
  logic [NREQ-1:0] e_gnt;
  logic            e_start;
  logic [DW-1:0]   e_data;
  logic [1:0]      e_owner;
  logic            e_err;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or negedge ret) begin
    if (!ret) begin
      m_ph <= 0; m_ptr <= 0; m_wait <= 0;
      e_gnt <= '0; e_start <= 1'b0; e_data <= '0; e_owner <= '0; e_err <= 1'b0;
    end else begin
      e_gnt <= '0; e_start <= 1'b0; e_err <= 1'b0;
      if (m_ph == 0) begin
        if (en && rr_pick(req, m_ptr) >= 0) begin
          e_gnt   <= NREQ'(1) << rr_pick(req, m_ptr);
          e_start <= 1'b1;
          e_data  <= req_data[rr_pick(req, m_ptr)*DW +: DW];
          e_owner <= 2'(rr_pick(req, m_ptr));
          m_ptr   <= (rr_pick(req, m_ptr) + 1) % NREQ;
          m_wait  <= 0;
          m_ph    <= 1;
        end
      end else if (m_ph == 1) begin
        if (tx_busy) m_ph <= 2;
        else if (m_wait + 1 >= TMO) begin e_err <= 1'b1; m_ph <= 0; end
        else m_wait <= m_wait + 1;
      end else begin
        if (!tx_busy) m_ph <= 0;
      end
    end
  end

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc_no   = 0;

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    tot_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // uart_tx stand-in
  bit tx_stuck = 0;
  int tx_dly = 1, tx_len = 2, cnt_d = 0, cnt_l = 0;
  logic [NREQ-1:0] drop = '0;

  // One clock: compare against the model, then advance tx model and requesters.
  task automatic cyc();
    @(negedge clk);
    cyc_no++;
    if (ret) begin
      chk(gnt == e_gnt && tx_start == e_start && tx_data == e_data &&
          owner == e_owner && active == (m_ph != 0) && err == e_err, "model",
          {gnt, tx_start, tx_data, owner, active, err},
          {e_gnt, e_start, e_data, e_owner, (m_ph != 0), e_err});
      if (cnt_l > 0) begin cnt_l--; if (cnt_l == 0) tx_busy = 1'b0; end
      if (cnt_d > 0) begin
        cnt_d--;
        if (cnt_d == 0) begin tx_busy = 1'b1; cnt_l = tx_len; end
      end
      if (tx_start && !tx_stuck) cnt_d = tx_dly;
      for (int i = 0; i < NREQ; i++) if (gnt[i] && drop[i]) req[i] = 1'b0;
    end
  endtask

  task automatic wait_gnt(input string nm);
    int n = 0;
    while (gnt == '0 && n < 60) begin cyc(); n++; end
    if (n >= 60) chk(1'b0, {nm, "_timeout"}, n, 60);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (active && n < 60) begin cyc(); n++; end
    if (n >= 60) chk(1'b0, {nm, "_timeout"}, n, 60);
  endtask

  task automatic check_zero(input string nm);
    chk(gnt == 0 && tx_start == 0 && tx_data == 0 && owner == 0 && active == 0 && err == 0,
        nm, {gnt, tx_start, tx_data, owner, active, err}, 0);
  endtask

  task automatic reset_pulse();
    @(negedge clk); #2;
    ret = 1'b0; tx_busy = 1'b0; cnt_d = 0; cnt_l = 0;
    #1 check_zero("reset_async");
    @(negedge clk); #2 ret = 1'b1;
  endtask

  int seq[6] = '{0, 1, 2, 3, 0, 1};
  int t0, t1, got;

  initial begin
    #1 check_zero("reset_init");
    @(negedge clk); #2 ret = 1'b1;
    en = 1'b1;

    // 1: single requester 2
    req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    tx_dly = 3; tx_len = 10; drop = 4'b1111;
    req = 4'b0100;
    wait_gnt("t1");
    chk(gnt == 4'b0100, "t1_gnt", gnt, 4'b0100);
    chk(tx_start == 1'b1, "t1_start", tx_start, 1);
    chk(tx_data == 8'hA5, "t1_data", tx_data, 8'hA5);
    chk(owner == 2'd2, "t1_owner", owner, 2);
    cyc();
    chk(gnt == 0 && tx_start == 0, "t1_pulse_1cyc", {gnt, tx_start}, 0);
    wait_idle("t1");

    // 2: all requesters holding, fresh pointer
    reset_pulse();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    tx_dly = 1; tx_len = 2; drop = 4'b0000;
    req = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      wait_gnt("t2");
      got = 0;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) got = i;
      chk(got == seq[g], "t2_order", got, seq[g]);
      chk(tx_data == 8'h11 * (seq[g] + 1), "t2_data", tx_data, 8'h11 * (seq[g] + 1));
      cyc();
    end
    req = '0;
    wait_idle("t2");

    // 3: pointer now at 2; requesters 1 and 3
    drop = 4'b1111;
    req = 4'b1010;
    wait_gnt("t3a");
    chk(gnt == 4'b1000, "t3_first", gnt, 4'b1000);
    cyc();
    wait_gnt("t3b");
    chk(gnt == 4'b0010, "t3_second", gnt, 4'b0010);
    cyc();
    wait_idle("t3");

    // 4: uart_tx never responds
    tx_stuck = 1;
    req = 4'b0001;
    wait_gnt("t4");
    t0 = cyc_no;
    cyc();
    begin
      int n = 0;
      while (!err && n < 60) begin cyc(); n++; end
      if (n >= 60) chk(1'b0, "t4_err_timeout", n, 60);
    end
    t1 = cyc_no;
    chk(t1 - t0 == TMO, "t4_err_delay", t1 - t0, TMO);
    chk(active == 1'b0, "t4_idle_at_err", active, 0);
    cyc();
    chk(err == 1'b0, "t4_err_1cyc", err, 0);
    tx_stuck = 0;
    req = 4'b0100;
    wait_gnt("t4b");
    chk(gnt == 4'b0100, "t4_regrant", gnt, 4'b0100);
    cyc();
    wait_idle("t4b");

    // 5: en drops during SEND
    tx_dly = 1; tx_len = 6;
    req = 4'b0001;
    wait_gnt("t5");
    cyc();
    req = 4'b0001;
    begin
      int n = 0;
      while (!tx_busy && n < 20) begin cyc(); n++; end
    end
    en = 1'b0;
    wait_idle("t5");
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk(gnt == 0 && active == 0, "t5_no_gnt", {gnt, active}, 0);
    end
    en = 1'b1;
    cyc();
    chk(gnt == 4'b0001, "t5_gnt_after_en", gnt, 4'b0001);
    cyc();
    wait_idle("t5b");

    // 6: reset in the middle of a frame
    tx_dly = 1; tx_len = 10;
    req = 4'b0010;
    wait_gnt("t6");
    repeat (4) cyc();
    chk(active == 1'b1 && tx_busy == 1'b1, "t6_in_send", {active, tx_busy}, 2'b11);
    reset_pulse();
    req = 4'b1000;
    wait_gnt("t6b");
    chk(gnt == 4'b1000, "t6_first_gnt", gnt, 4'b1000);
    chk(owner == 2'd3, "t6_owner", owner, 3);
    cyc();
    wait_idle("t6b");

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
